store_write_buffer: RTL

- Posted-write buffer between the CPU store path and the byte-enabled data memory.
- Accepts word-aligned stores: word address, 32-bit lane-positioned data, 4-bit byte-enable mask, as produced by the store data encoder.
- Queues the stores, merges back-to-back stores to the same word, and drains them to memory over a req/ack handshake.
- Flags loads that hit a pending store so the pipeline can stall them until the store drains.

---
 rtl/store_write_buffer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// ----------------------------------------------------------------------------
// store_write_buffer
//
// Posted-write buffer sitting between the CPU store path and a byte-enabled
// data memory. Stores are queued in a small circular FIFO, a store to the
// same word as the newest queued entry is merged into it lane by lane, and
// the head entry is drained to memory over a registered req/ack handshake.
// Loads are checked against every pending entry so the pipeline can stall a
// load until the store it depends on has drained.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   st_valid   store request
//   st_ready   buffer can take a store this cycle (new entry or merge)
//   st_addr    store word address
//   st_data    store data, already lane-positioned
//   st_be      byte enables; bit0 = data[31:24] ... bit3 = data[7:0]
//   mem_req    memory write request (registered)
//   mem_ack    memory accepted the current write
//   mem_addr   write word address (registered)
//   mem_wdata  write data (registered)
//   mem_be     write byte enables (registered)
//   ld_valid   load lookup valid
//   ld_addr    load word address
//   ld_hit     load address matches a pending entry
//   count      number of valid entries
//   empty      count == 0
// ----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_be,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Entry storage. Validity is implied by head/count, so the arrays
    // themselves need no reset.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;

    logic [PW-1:0] newest;
    logic          merge_ok;
    logic          accept;
    logic          do_push;
    logic          do_merge;
    logic          do_pop;
    logic          load_mem;
    logic          head_fwd;
    logic [31:0]   merge_data;
    logic [3:0]    merge_be;
    logic [DEPTH-1:0] hit_vec;

    assign newest = tail_reg - PW'(1);

    // The newest entry may absorb a store unless it is the write already
    // presented to memory, whose mem_* outputs must stay stable.
    assign merge_ok = (count_reg != '0)
                   && (st_addr == addr_mem[newest])
                   && !((newest == head_reg) && (state_reg == ISSUE));

    // No push-through when full: a pop in the same cycle does not free a slot.
    assign st_ready = (count_reg < CW'(DEPTH)) || merge_ok;

    // A store with no byte enables is accepted but has no effect.
    assign accept   = st_valid && st_ready && (st_be != 4'b0000);
    assign do_merge = accept && merge_ok;
    assign do_push  = accept && !merge_ok;

    // Lane-wise merge of the incoming store over the newest entry.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merge_data[31-8*gi -: 8] = st_be[gi] ? st_data[31-8*gi -: 8]
                                                        : data_mem[newest][31-8*gi -: 8];
        end
    endgenerate
    assign merge_be = be_mem[newest] | st_be;

    // When the head is loaded into mem_* in the same cycle a store merges
    // into it, the merged value must be issued, otherwise the merged bytes
    // would be lost when the entry pops.
    assign head_fwd = do_merge && (newest == head_reg);

    // Next-state / control logic.
    always_comb begin
        state_next = state_reg;
        load_mem   = 1'b0;
        do_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    load_mem   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    do_pop     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, pointers, and registered memory interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state_reg <= state_next;
            if (do_push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (do_pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (load_mem) begin
                mem_req   <= 1'b1;
                mem_addr  <= addr_mem[head_reg];
                mem_wdata <= head_fwd ? merge_data : data_mem[head_reg];
                mem_be    <= head_fwd ? merge_be   : be_mem[head_reg];
            end else if (do_pop) begin
                mem_req   <= 1'b0;
            end
        end
    end

    // Entry write port: either a fresh allocation at tail or a merge into
    // the newest entry (never both in one cycle).
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[tail_reg] <= st_addr;
            data_mem[tail_reg] <= st_data;
            be_mem[tail_reg]   <= st_be;
        end else if (do_merge) begin
            data_mem[newest]   <= merge_data;
            be_mem[newest]     <= merge_be;
        end
    end

    // Load hazard lookup over every valid entry; an entry is valid when its
    // distance from head (modulo DEPTH) is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - head_reg;
            assign hit_vec[gi] = ({1'b0, offset} < count_reg)
                              && (addr_mem[gi] == ld_addr);
        end
    endgenerate

    assign ld_hit = ld_valid && (|hit_vec);
    assign count  = count_reg;
    assign empty  = (count_reg == '0);

endmodule
